two_phase_clk_ctrl: RTL and testbench
=====================================

Name: two_phase_clk_ctrl

Overview:
- Sequencer for the two-phase non-overlapping clock scheme. It generates single-clock-domain enables `ph1_en` and `ph2_en` in place of gated clocks.
- Phase widths and dead-time gaps are programmable. Runs either a fixed number of periods or continuously, with a graceful stop.
- Sits between the configuration/control logic and any two-phase datapath that qualifies its registers with `ph1_en`/`ph2_en`.

Parameters:
- CNT_W, 8, width of phase/gap length fields and the internal phase timer
- NCYC_W, 16, width of the period count request and `cycle_cnt`

Ports:
- clk  input  1  system clock; all state on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin sequence; sampled only in IDLE
- stop  input  1  request graceful stop after the current period
- ph1_len  input  CNT_W  phase-1 high time in clk cycles (0 treated as 1)
- ph2_len  input  CNT_W  phase-2 high time in clk cycles (0 treated as 1)
- gap_len  input  CNT_W  dead time after each phase (0 = no gap state)
- n_cycles  input  NCYC_W  periods to run; 0 = continuous until stop
- ph1_en  output  1  phase-1 enable, registered
- ph2_en  output  1  phase-2 enable, registered
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse on return to IDLE
- cycle_cnt  output  NCYC_W  completed periods since last start

Behaviour:
- Reset (async, immediate, any state): state=IDLE; ph1_en=0, ph2_en=0, busy=0, done=0, cycle_cnt=0; stop latch cleared.
- States and transitions:
  - IDLE → PH1 on start.
  - PH1 → GAP1 after ph1_len cycles.
  - GAP1 → PH2 after gap_len cycles.
  - PH2 → GAP2 after ph2_len cycles.
  - GAP2 → PH1 or IDLE after gap_len cycles.
  - If gap_len=0, GAP1/GAP2 are skipped: PH1 → PH2 directly, and the period ends at the end of PH2.
- Outputs decoded from the registered state:
  - ph1_en=1 only in PH1; ph2_en=1 only in PH2.
  - ph1_en and ph2_en are never high in the same cycle, under any configuration or event.
- Config latch: ph1_len, ph2_len, gap_len and n_cycles are captured on the edge that samples start in IDLE. Input changes while busy have no effect until the next start.
- Start latency: start high at edge N (in IDLE) → ph1_en=1 and busy=1 in the cycle following edge N. cycle_cnt clears to 0 on that same edge.
- Period end (last cycle of GAP2, or of PH2 when gap_len=0): cycle_cnt increments by 1, wrapping modulo 2^NCYC_W. Then:
  - a. If the stop latch is set, or n_cycles≠0 and the incremented cycle_cnt equals n_cycles → IDLE, done=1 for one cycle, busy=0.
  - b. Otherwise → PH1, with no extra idle cycle between periods.
- Stop:
  - stop high in any non-IDLE state sets a sticky latch; the current period always completes.
  - stop in the same cycle as the period end counts for that period.
  - stop in IDLE is ignored, including when it coincides with start (start wins; latch stays clear).
- start while busy: ignored, not queued.
- Period length = max(ph1_len,1) + max(ph2_len,1) + 2·gap_len cycles.
- Timer: one CNT_W down-counter loaded on each state entry with (len−1). Length 0 loads 0, giving one cycle.
- done is registered and asserted only in the first IDLE cycle after a run. It is never asserted after reset.
- Reset asserted mid-phase: enables drop asynchronously with no completion and no done pulse.

Decomposition:
- Shared package `clk_ctrl_pkg`:
  - state enum (IDLE, PH1, GAP1, PH2, GAP2)
  - default CNT_W and NCYC_W constants
  - helper to clamp a length of 0 to 1
- One natural sub-module, `phase_timer`: loadable CNT_W down-counter with a `load` input, a `len` input and an `expire` output. The top level holds the FSM, config latch, stop latch and cycle counter.

Test Plan:
- Reset mid-PH1 (ph1_len=5, third cycle) → ph1_en drops without a clock edge; busy=0, done=0, cycle_cnt=0.
- ph1_len=2, ph2_len=3, gap_len=1, n_cycles=2, start pulse → pattern per period is ph1 2 cycles, gap 1, ph2 3, gap 1 (period 7). cycle_cnt reads 1 then 2. done pulses once, 14 cycles after the first ph1_en cycle. ph1_en&ph2_en never 1.
- ph1_len=0, ph2_len=0, gap_len=0, n_cycles=3 → enables alternate every cycle (ph1, ph2, ph1, …). Period 2 cycles, 6 busy cycles, never overlapping, then done.
- n_cycles=0, lengths 4/4/2; stop pulsed in the second cycle of PH2 of period 5 → period 5 completes. cycle_cnt=5, done pulses, no sixth ph1_en.
- start and stop together in IDLE → run proceeds (stop ignored). start re-pulsed while busy with new ph1_len=9 → ignored; the old config holds for the whole run.
- NCYC_W=4 override, n_cycles=0, run 17 periods, then stop → cycle_cnt wraps 15→0 and ends at 1. The sequence is uninterrupted.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the two-phase non-overlapping clock sequencer.
package clk_ctrl_pkg;
  localparam int CNT_W_DEF  = 8;
  localparam int NCYC_W_DEF = 16;

  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH2, GAP2} state_t;

  // A programmed length of zero still occupies one clock cycle.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction
endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing each phase/gap; expire marks the last cycle of the interval.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);
  logic [CNT_W-1:0] cnt;

  // len arrives already clamped to at least 1, so len-1 never underflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= len - CNT_W'(1);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/two_phase_clk_ctrl.sv
// Two-phase non-overlapping enable sequencer: PH1 -> GAP1 -> PH2 -> GAP2 per period,
// with config latched at start, counted or continuous runs, and a graceful sticky stop.
module two_phase_clk_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int NCYC_W = NCYC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  ph1_len,
  input  logic [CNT_W-1:0]  ph2_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic [NCYC_W-1:0] n_cycles,
  output logic              ph1_en,
  output logic              ph2_en,
  output logic              busy,
  output logic              done,
  output logic [NCYC_W-1:0] cycle_cnt,
  output state_t            dbg_state
);
  state_t            state, nxt;
  logic [CNT_W-1:0]  cfg_ph1, cfg_ph2, cfg_gap;
  logic [NCYC_W-1:0] cfg_n, cnt_inc;
  logic              stop_lat, period_end, finish;
  logic              t_load, t_expire;
  logic [CNT_W-1:0]  t_len, t_len_c;

  always_comb begin
    nxt        = state;
    t_load     = 1'b0;
    t_len      = '0;
    period_end = 1'b0;
    case (state)
      IDLE: if (start) begin
        nxt    = PH1;
        t_load = 1'b1;
        t_len  = ph1_len;
      end
      PH1: if (t_expire) begin
        t_load = 1'b1;
        if (cfg_gap != '0) begin
          nxt   = GAP1;
          t_len = cfg_gap;
        end else begin
          nxt   = PH2;
          t_len = cfg_ph2;
        end
      end
      GAP1: if (t_expire) begin
        nxt    = PH2;
        t_load = 1'b1;
        t_len  = cfg_ph2;
      end
      PH2: if (t_expire) begin
        if (cfg_gap != '0) begin
          nxt    = GAP2;
          t_load = 1'b1;
          t_len  = cfg_gap;
        end else begin
          period_end = 1'b1;
        end
      end
      GAP2: if (t_expire) period_end = 1'b1;
      default: nxt = IDLE;
    endcase

    // A stop arriving on the period-end cycle itself still ends this period.
    cnt_inc = cycle_cnt + NCYC_W'(1);
    finish  = period_end &&
              (stop_lat || stop || (cfg_n != '0 && cnt_inc == cfg_n));
    if (period_end) begin
      if (finish) begin
        nxt = IDLE;
      end else begin
        nxt    = PH1;
        t_load = 1'b1;
        t_len  = cfg_ph1;
      end
    end
  end

  assign t_len_c = CNT_W'(clamp_len(32'(t_len)));

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .len    (t_len_c),
    .expire (t_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ph1   <= '0;
      cfg_ph2   <= '0;
      cfg_gap   <= '0;
      cfg_n     <= '0;
      stop_lat  <= 1'b0;
      cycle_cnt <= '0;
      ph1_en    <= 1'b0;
      ph2_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= nxt;
      ph1_en <= (nxt == PH1);
      ph2_en <= (nxt == PH2);
      busy   <= (nxt != IDLE);
      done   <= finish;
      if (state == IDLE) begin
        if (start) begin
          cfg_ph1   <= ph1_len;
          cfg_ph2   <= ph2_len;
          cfg_gap   <= gap_len;
          cfg_n     <= n_cycles;
          cycle_cnt <= '0;
          stop_lat  <= 1'b0;
        end
      end else begin
        if (period_end) cycle_cnt <= cnt_inc;
        if (finish)
          stop_lat <= 1'b0;
        else if (stop)
          stop_lat <= 1'b1;
      end
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_two_phase_clk_ctrl.sv
// Directed bench for two_phase_clk_ctrl: default instance plus a 4-bit cycle counter instance.
module tb_two_phase_clk_ctrl;
  import clk_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, stop;
  logic [7:0]  ph1_len, ph2_len, gap_len;
  logic [15:0] n_cycles;
  logic        ph1_en, ph2_en, busy, done;
  logic [15:0] cycle_cnt;
  state_t      dbg_state;

  logic        w_start, w_stop;
  logic [3:0]  w_n_cycles;
  logic        w_ph1_en, w_ph2_en, w_busy, w_done;
  logic [3:0]  w_cycle_cnt;
  state_t      w_dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  two_phase_clk_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ph1_len(ph1_len), .ph2_len(ph2_len), .gap_len(gap_len), .n_cycles(n_cycles),
    .ph1_en(ph1_en), .ph2_en(ph2_en), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt), .dbg_state(dbg_state)
  );

  two_phase_clk_ctrl #(.CNT_W(8), .NCYC_W(4)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .stop(w_stop),
    .ph1_len(ph1_len), .ph2_len(ph2_len), .gap_len(gap_len), .n_cycles(w_n_cycles),
    .ph1_en(w_ph1_en), .ph2_en(w_ph2_en), .busy(w_busy), .done(w_done),
    .cycle_cnt(w_cycle_cnt), .dbg_state(w_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    w_start = 1'b0; w_stop = 1'b0; w_n_cycles = 4'd0;
    ph1_len = 8'd0; ph2_len = 8'd0; gap_len = 8'd0; n_cycles = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ph1", ph1_en, 0);
    check("rst_ph2", ph2_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", cycle_cnt, 0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);

    // Reset in the third cycle of PH1 drops enables without a clock edge
    ph1_len = 8'd5; ph2_len = 8'd5; gap_len = 8'd1; n_cycles = 16'd1;
    start_run();
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_ph1", ph1_en, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_ph1", ph1_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cnt", cycle_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_after_done", done, 0);

    // 2/3/1, two periods of 7 cycles
    ph1_len = 8'd2; ph2_len = 8'd3; gap_len = 8'd1; n_cycles = 16'd2;
    start_run();
    for (int i = 0; i < 14; i++) begin
      check("t2_ph1", ph1_en, (i % 7) < 2);
      check("t2_ph2", ph2_en, (i % 7) >= 3 && (i % 7) <= 5);
      check("t2_busy", busy, 1);
      check("t2_done", done, 0);
      check("t2_cnt", cycle_cnt, i / 7);
      check("t2_ovl", ph1_en & ph2_en, 0);
      @(negedge clk);
    end
    check("t2_done_end", done, 1);
    check("t2_busy_end", busy, 0);
    check("t2_cnt_end", cycle_cnt, 2);
    @(negedge clk);
    check("t2_done_once", done, 0);

    // Zero lengths: enables alternate each cycle, three periods
    ph1_len = 8'd0; ph2_len = 8'd0; gap_len = 8'd0; n_cycles = 16'd3;
    start_run();
    for (int i = 0; i < 6; i++) begin
      check("t3_ph1", ph1_en, (i % 2) == 0);
      check("t3_ph2", ph2_en, (i % 2) == 1);
      check("t3_busy", busy, 1);
      check("t3_ovl", ph1_en & ph2_en, 0);
      @(negedge clk);
    end
    check("t3_done", done, 1);
    check("t3_busy_end", busy, 0);
    check("t3_cnt", cycle_cnt, 3);

    // Continuous 4/4/2 (period 12), stop in second PH2 cycle of period 5
    ph1_len = 8'd4; ph2_len = 8'd4; gap_len = 8'd2; n_cycles = 16'd0;
    @(negedge clk);
    start_run();
    for (int i = 0; i < 60; i++) begin
      check("t4_ph1", ph1_en, (i % 12) < 4);
      check("t4_ph2", ph2_en, (i % 12) >= 6 && (i % 12) < 10);
      check("t4_busy", busy, 1);
      check("t4_done", done, 0);
      stop = (i == 55);
      @(negedge clk);
    end
    stop = 1'b0;
    check("t4_done_end", done, 1);
    check("t4_cnt", cycle_cnt, 5);
    check("t4_ph1_end", ph1_en, 0);
    check("t4_busy_end", busy, 0);
    @(negedge clk);
    check("t4_no_sixth", ph1_en, 0);
    check("t4_done_once", done, 0);

    // start+stop in IDLE: stop ignored; restart while busy ignored
    ph1_len = 8'd1; ph2_len = 8'd1; gap_len = 8'd1; n_cycles = 16'd2;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t5_ph1", ph1_en, (i % 4) == 0);
      check("t5_ph2", ph2_en, (i % 4) == 2);
      check("t5_busy", busy, 1);
      check("t5_done", done, 0);
      start = (i == 1);
      if (i == 1) ph1_len = 8'd9;
      @(negedge clk);
    end
    start = 1'b0;
    check("t5_done_end", done, 1);
    check("t5_cnt", cycle_cnt, 2);
    @(negedge clk);
    check("t5_no_queue", busy, 0);

    // 4-bit counter: 17 continuous periods, stop on the last period-end cycle
    ph1_len = 8'd0; ph2_len = 8'd0; gap_len = 8'd0; w_n_cycles = 4'd0;
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int i = 0; i < 34; i++) begin
      check("t6_ph1", w_ph1_en, (i % 2) == 0);
      check("t6_ph2", w_ph2_en, (i % 2) == 1);
      check("t6_busy", w_busy, 1);
      check("t6_cnt", w_cycle_cnt, (i / 2) % 16);
      w_stop = (i == 33);
      @(negedge clk);
    end
    w_stop = 1'b0;
    check("t6_done", w_done, 1);
    check("t6_cnt_end", w_cycle_cnt, 1);
    check("t6_busy_end", w_busy, 0);
    check("t6_ph1_end", w_ph1_en, 0);
    @(negedge clk);
    check("t6_done_once", w_done, 0);
    check("t6_state", w_dbg_state, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
